// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: ball motion, wall/paddle bounce, scoring and serve/hold sequencing for a pong game
module pong_ball_ctrl #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 10,
    parameter int BALL_SPEED  = 2,
    parameter int PADDLE_H    = 60,
    parameter int PADDLE_W    = 10,
    parameter int PADDLE_X_L  = 20,
    parameter int PADDLE_X_R  = 610,
    parameter int HOLD_FRAMES = 60,
    parameter int WIN_SCORE   = 9
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic [9:0] left_paddle_Y,
    input  logic [9:0] right_paddle_Y,
    output logic [9:0] ball_X_location,
    output logic [9:0] ball_Y_location,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [1:0] state,
    output logic       point_pulse
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PLAY      = 2'd1;
    localparam logic [1:0] SCORED    = 2'd2;
    localparam logic [1:0] GAME_OVER = 2'd3;

    // 12-bit working width keeps X+size+speed and paddle_Y+height from wrapping
    localparam logic [11:0] CX    = 12'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [11:0] CY    = 12'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [11:0] SW    = 12'(SCREEN_W);
    localparam logic [11:0] SH    = 12'(SCREEN_H);
    localparam logic [11:0] BS    = 12'(BALL_SIZE);
    localparam logic [11:0] SP    = 12'(BALL_SPEED);
    localparam logic [11:0] PH    = 12'(PADDLE_H);
    localparam logic [11:0] PXL_E = 12'(PADDLE_X_L + PADDLE_W);
    localparam logic [11:0] PXR   = 12'(PADDLE_X_R);
    localparam logic [5:0]  HOLD_LAST = 6'(HOLD_FRAMES - 1);
    localparam logic [3:0]  WIN   = 4'(WIN_SCORE);

    logic [11:0] x_q, x_d, y_q, y_d;
    logic        dx_q, dx_d, dy_q, dy_d, sdir_q, sdir_d, pulse_q, pulse_d;
    logic [1:0]  st_q, st_d;
    logic [3:0]  sl_q, sl_d, sr_q, sr_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [11:0] lpy, rpy;
    logic        vl, vr, lhit, rhit, lmiss, rmiss, top, bot;

    assign lpy   = {2'b00, left_paddle_Y};
    assign rpy   = {2'b00, right_paddle_Y};
    assign vl    = (y_q + BS > lpy) && (y_q < lpy + PH);
    assign vr    = (y_q + BS > rpy) && (y_q < rpy + PH);
    assign lhit  = !dx_q && (x_q >= PXL_E) && (x_q < PXL_E + SP) && vl;
    assign rhit  = dx_q && (x_q + BS <= PXR) && (x_q + BS + SP > PXR) && vr;
    assign lmiss = !dx_q && (x_q < SP) && !lhit;
    assign rmiss = dx_q && (x_q + BS + SP > SW) && !rhit;
    assign top   = !dy_q && (y_q < SP);
    assign bot   = dy_q && (y_q + BS + SP > SH);

    // next-state: serve handling, per-frame motion with bounces, scoring and hold countdown
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sdir_d  = sdir_q;
        st_d    = st_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (st_q)
            IDLE: if (serve) begin
                st_d = PLAY;
                dx_d = sdir_q;
                dy_d = 1'b1;
            end
            PLAY: if (frame_tick) begin
                x_d  = lhit ? PXL_E : rhit ? PXR - BS : dx_q ? x_q + SP : x_q - SP;
                dx_d = lhit ? 1'b1 : rhit ? 1'b0 : dx_q;
                y_d  = top ? 12'd0 : bot ? SH - BS : dy_q ? y_q + SP : y_q - SP;
                dy_d = top ? 1'b1 : bot ? 1'b0 : dy_q;
                if (lmiss || rmiss) begin
                    x_d     = CX;
                    y_d     = CY;
                    st_d    = SCORED;
                    cnt_d   = 6'd0;
                    pulse_d = 1'b1;
                    sdir_d  = rmiss;
                    sr_d    = (lmiss && sr_q != WIN) ? sr_q + 4'd1 : sr_q;
                    sl_d    = (rmiss && sl_q != WIN) ? sl_q + 4'd1 : sl_q;
                end
            end
            SCORED: if (frame_tick) begin
                cnt_d = (cnt_q == HOLD_LAST) ? 6'd0 : cnt_q + 6'd1;
                st_d  = (cnt_q != HOLD_LAST) ? SCORED : (sl_q == WIN || sr_q == WIN) ? GAME_OVER : IDLE;
            end
            default: if (serve) begin
                sl_d   = 4'd0;
                sr_d   = 4'd0;
                sdir_d = 1'b1;
                st_d   = IDLE;
            end
        endcase
    end

    // state registers with synchronous reset to a centred ball heading right/down
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            x_q     <= CX;
            y_q     <= CY;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            sdir_q  <= 1'b1;
            st_q    <= IDLE;
            sl_q    <= 4'd0;
            sr_q    <= 4'd0;
            cnt_q   <= 6'd0;
            pulse_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            sdir_q  <= sdir_d;
            st_q    <= st_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign ball_X_location = x_q[9:0];
    assign ball_Y_location = y_q[9:0];
    assign score_left      = sl_q;
    assign score_right     = sr_q;
    assign state           = st_q;
    assign point_pulse     = pulse_q;
endmodule
